key_debounce: RTL
=================

# key_debounce

Debounces and conditions the active-low push-button input on the `ADC_CLK_10` domain of the board top level. `key_debounce` synchronizes raw `KEY`, filters bounce with a stability counter, and produces a clean level plus single-cycle press and release strobes. It also keeps a wrapping press counter, and can optionally generate auto-repeat strobes while the key is held. It sits between the `KEY` pin and the control logic that drives `LEDR`/`HEX`.

## Interface
- `STABLE_CYCLES`, 10000, consecutive identical synchronized samples needed to accept a level change (1 ms at 10 MHz); must be ≥ 1
- `REPEAT_DELAY`, 5000000, cycles in HELD before the first `repeat_pulse`; must be ≥ 1
- `REPEAT_RATE`, 1000000, cycles between later `repeat_pulse`s; must be ≥ 1

- `ADC_CLK_10`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `KEY`  in  1  raw button, active-low (0 = pressed), asynchronous to `ADC_CLK_10`
- `pressed`  out  1  debounced level, 1 = held
- `press_pulse`  out  1  one-cycle strobe on accepted press
- `release_pulse`  out  1  one-cycle strobe on accepted release
- `repeat_pulse`  out  1  one-cycle auto-repeat strobe (tied 0 when the feature is compiled out)
- `press_count`  out  8  accepted presses, modulo 256

## Operation
- Synchronizer: 2 flops with reset value 1 (released). Filtering acts only on the second-stage sample `s`.
- Reset values: all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE: released and stable. `s`=0 → PRESS_WAIT, counter = 1.
  - PRESS_WAIT:
    - `s`=1 → IDLE, counter = 0 (bounce rejected).
    - `s`=0 and counter == STABLE_CYCLES → HELD; `pressed` rises; `press_pulse` asserts; `press_count` increments.
    - Otherwise counter increments.
  - HELD: `s`=1 → RELEASE_WAIT, counter = 1.
  - RELEASE_WAIT:
    - `s`=0 → HELD, counter = 0. No pulse; the repeat timer is not restarted.
    - `s`=1 and counter == STABLE_CYCLES → IDLE; `pressed` falls; `release_pulse` asserts.
    - Otherwise counter increments.
- `press_count` wraps from 255 to 0 with no flag. It increments on `press_pulse` only, never on `repeat_pulse`.
- The filter counter width is wide enough for STABLE_CYCLES with no overflow.
- At most one of `press_pulse`, `release_pulse`, `repeat_pulse` is high in any cycle.
- Behaviour with `STABLE_CYCLES`=1: acceptance after a single low sample in PRESS_WAIT.

## Timing
- All outputs are registered.
- Press latency: `KEY` sampled low at edge 0 and held low → `press_pulse` high during exactly one cycle, starting after edge STABLE_CYCLES+2.
- `pressed` rises in that same cycle.
- Release latency is symmetric: STABLE_CYCLES+2 edges to `release_pulse` and the fall of `pressed`.
- Any glitch shorter than STABLE_CYCLES synchronized cycles produces no output change.
- Reset asserted mid-operation: all state clears immediately, asynchronously. After deassertion, a key still held low is re-qualified from IDLE with full latency and produces a fresh `press_pulse`.

## Configuration
- Macro: `KEY_DEBOUNCE_REPEAT_EN`.
- Defined:
  - The repeat counter runs in HELD, starting at 0 on entry from PRESS_WAIT.
  - First `repeat_pulse` comes REPEAT_DELAY cycles after the `press_pulse` cycle; later pulses come every REPEAT_RATE cycles.
  - The counter pauses in RELEASE_WAIT and resumes if the state returns to HELD.
  - The counter clears on entry to IDLE.
- Undefined: no repeat counter is built; `repeat_pulse` is constant 0. All other behaviour is identical.

## Structure
- `key_debounce_pkg`: state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and a counter-width function based on `$clog2`.
- Sub-module `sync_2ff`: two-flop synchronizer with a reset-value parameter; `key_debounce` instantiates it once, with reset value 1.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=8, and a 100 ns clock.
- Clean press: `KEY` 1→0 and held → exactly one `press_pulse` after edge 6; `pressed`=1; `press_count`=1.
- Bounce on press: `KEY` 0 for 2 cycles, 1 for 1 cycle, then 0 steady → no pulse until 6 edges after the final fall; exactly one `press_pulse`.
- Release with bounce: from HELD, `KEY` 1 for 3 cycles, 0 for 1 cycle, then 1 steady → `pressed` stays 1 through the bounce; one `release_pulse` 6 edges after the final rise; `press_count` unchanged.
- Wrap: 256 clean press/release cycles → `press_count` returns to 0; one `press_pulse` per cycle.
- Auto-repeat (macro defined): hold 60 cycles after `press_pulse` → `repeat_pulse` at +20, +28, +36, +44, +52, +60. With the macro undefined: none.
- Reset while in PRESS_WAIT with `KEY`=0 → outputs 0 immediately; after deassertion, `press_pulse` follows after 6 edges; `press_count`=1.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the key debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizer, stability-counter FSM, press/release strobes, press counter.
// Optional auto-repeat strobes are built when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 10000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_RATE   = 1000000
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic       KEY,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  localparam int            CW         = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("key_debounce: STABLE_CYCLES, REPEAT_DELAY and REPEAT_RATE must all be >= 1");
  end

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pressed_nx, press_nx, release_nx;
  logic [7:0]    count_nx;
  logic          s;  // synchronized KEY, low = pressed

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (ADC_CLK_10),
    .reset (reset),
    .d     (KEY),
    .q     (s)
  );

  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pressed       <= pressed_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      press_count   <= count_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pressed_nx = pressed;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    count_nx   = press_count;
    case (state)
      IDLE: begin
        if (!s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == STABLE_MAX) begin
          state_nx   = HELD;
          pressed_nx = 1'b1;
          press_nx   = 1'b1;
          count_nx   = press_count + 8'd1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!s) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == STABLE_MAX) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          pressed_nx = 1'b0;
          release_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int            RW        = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [RW-1:0] DELAY_MAX = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_MAX  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] RPT_ONE   = RW'(1);

  logic [RW-1:0] rpt_cnt, rpt_inc, rpt_target;
  logic          rpt_armed;  // first (delayed) repeat already issued

  assign rpt_inc    = rpt_cnt + RPT_ONE;
  assign rpt_target = rpt_armed ? RATE_MAX : DELAY_MAX;

  // Counts only while staying in HELD, so it freezes across a release bounce.
  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      rpt_cnt      <= '0;
      rpt_armed    <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state_nx == IDLE || (state == PRESS_WAIT && state_nx == HELD)) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else if (state == HELD && state_nx == HELD) begin
        if (rpt_inc == rpt_target) begin
          rpt_cnt      <= '0;
          rpt_armed    <= 1'b1;
          repeat_pulse <= 1'b1;
        end else begin
          rpt_cnt <= rpt_inc;
        end
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
